fir_burst_scheduler: RTL and testbench

FIR_BURST_SCHEDULER -- requirements
Module: fir_burst_scheduler

---
 rtl/fir_burst_scheduler.sv | 143 ++++++++++++++
 tb/tb_fir_burst_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_burst_scheduler.sv
// Round-robin burst scheduler that time-shares one FIR between NCH channels and
// zero-flushes the FIR between bursts so channel histories never mix.
module fir_burst_scheduler #(
    parameter int NCH   = 4,
    parameter int DW    = 8,
    parameter int BURST = 16,
    parameter int FLUSH = 8,
    parameter int LAT   = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NCH-1:0]         i_valid,
    input  logic [NCH*DW-1:0]      i_data,
    output logic [NCH-1:0]         o_ready,
    output logic [DW-1:0]          o_fir_data,
    input  logic [DW-1:0]          i_fir_data,
    output logic                   o_valid,
    output logic [DW-1:0]          o_data,
    output logic [$clog2(NCH)-1:0] o_chan,
    output logic [1:0]             o_state
);
    localparam int CW = $clog2(NCH);
    localparam int BW = $clog2(BURST + 1);
    localparam int FW = $clog2(FLUSH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] grant;
    logic [CW-1:0] last_grant;
    logic [BW-1:0] burst_cnt;
    logic [FW-1:0] flush_cnt;
    logic [DW-1:0] ch_data [NCH];

    logic          rr_any;
    logic [CW-1:0] rr_grant;
    logic [CW-1:0] cand;
    logic          hs;

    logic          tag_v [LAT+1];
    logic [CW-1:0] tag_c [LAT+1];

    for (genvar c = 0; c < NCH; c++) begin : g_unpack
        assign ch_data[c] = i_data[c*DW +: DW];
    end

    // Walk offsets from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        rr_any   = 1'b0;
        rr_grant = '0;
        cand     = '0;
        for (int i = NCH; i >= 1; i--) begin
            cand = CW'((int'(last_grant) + i) % NCH);
            if (i_valid[cand]) begin
                rr_any   = 1'b1;
                rr_grant = cand;
            end
        end
    end

    // Handshake: a sample moves when valid and ready are both high at a rising edge.
    assign hs      = (state == S_RUN) && i_valid[grant] && o_ready[grant];
    assign o_state = state;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_FLUSH;
            flush_cnt  <= '0;
            last_grant <= CW'(NCH - 1);
            grant      <= '0;
            burst_cnt  <= '0;
            o_ready    <= '0;
            o_fir_data <= '0;
        end else begin
            case (state)
                S_IDLE, S_FLUSH: begin
                    o_fir_data <= '0;
                    if (state == S_FLUSH && flush_cnt < FW'(FLUSH - 1)) begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end else if (rr_any) begin
                        grant      <= rr_grant;
                        last_grant <= rr_grant;
                        burst_cnt  <= '0;
                        o_ready    <= NCH'(1) << rr_grant;
                        state      <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (hs) begin
                        o_fir_data <= ch_data[grant];
                        burst_cnt  <= burst_cnt + 1'b1;
                        if (burst_cnt == BW'(BURST - 1)) begin
                            o_ready   <= '0;
                            flush_cnt <= '0;
                            state     <= S_FLUSH;
                        end
                    end else begin
                        // The starved cycle already pushes a zero, so it is flush cycle 1.
                        o_fir_data <= '0;
                        o_ready    <= '0;
                        flush_cnt  <= FW'(1);
                        state      <= S_FLUSH;
                    end
                end
                default: begin
                    o_ready <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // Tags ride alongside each FIR input sample and meet its result LAT+1 edges later.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i <= LAT; i++) begin
                tag_v[i] <= 1'b0;
                tag_c[i] <= '0;
            end
            o_valid <= 1'b0;
            o_data  <= '0;
            o_chan  <= '0;
        end else begin
            tag_v[0] <= hs;
            tag_c[0] <= grant;
            for (int i = 1; i <= LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_c[i] <= tag_c[i-1];
            end
            o_valid <= tag_v[LAT];
            if (tag_v[LAT]) begin
                o_data <= i_fir_data;
                o_chan <= tag_c[LAT];
            end
        end
    end
endmodule

// File: tb/tb_fir_burst_scheduler.sv
// Directed bench for fir_burst_scheduler; the shared FIR is modelled as a
// LAT-cycle delay that adds 0x40, so o_data must come from i_fir_data.
module tb_fir_burst_scheduler;
    localparam int NCH   = 4;
    localparam int DW    = 8;
    localparam int BURST = 16;
    localparam int FLUSH = 8;
    localparam int LAT   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    valid;
    logic [NCH*DW-1:0] data;
    logic [NCH-1:0]    ready;
    logic [DW-1:0]     fir_out;
    logic [DW-1:0]     fir_in;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_chan;
    logic [1:0]        state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    fir_burst_scheduler #(
        .NCH(NCH), .DW(DW), .BURST(BURST), .FLUSH(FLUSH), .LAT(LAT)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_valid    (valid),
        .i_data     (data),
        .o_ready    (ready),
        .o_fir_data (fir_out),
        .i_fir_data (fir_in),
        .o_valid    (out_valid),
        .o_data     (out_data),
        .o_chan     (out_chan),
        .o_state    (state_dbg)
    );

    always #5 clk = ~clk;

    // Shared FIR stand-in: two-cycle delay plus a fixed offset.
    logic [DW-1:0] fir_p0 = '0;
    logic [DW-1:0] fir_p1 = '0;
    always @(posedge clk) begin
        fir_p0 <= fir_out;
        fir_p1 <= fir_p0;
    end
    assign fir_in = fir_p1 + 8'h40;

    task automatic check(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp_v);
        end
    endtask

    // Leaves the caller at the falling edge right after the last reset edge.
    task automatic do_reset();
        rst   = 1'b1;
        valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_data(input int p);
        for (int c = 0; c < NCH; c++) data[c*DW +: DW] = 8'(c*32 + p + 1);
    endtask

    // Continuous requests on mask for nb bursts, starting right after reset.
    task automatic run_bursts(input string tag, input logic [3:0] mask, input int nb, input int t_end);
        int gseq[8];
        int last;
        int pulses;
        logic [7:0] exp_d;
        logic [1:0] exp_c;
        last   = NCH - 1;
        pulses = 0;
        exp_d  = '0;
        exp_c  = '0;
        for (int b = 0; b < nb; b++) begin
            bit found;
            found   = 1'b0;
            gseq[b] = 0;
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (last + k) % NCH;
                if (!found && mask[c]) begin
                    found   = 1'b1;
                    gseq[b] = c;
                end
            end
            last = gseq[b];
        end
        for (int t = 0; t <= t_end; t++) begin
            int u;
            logic [3:0] er;
            logic [7:0] ef;
            logic ev;
            valid = (t < 24*nb) ? mask : 4'b0;
            set_data(t >= 8 ? (t - 8) % 24 : 0);
            er = '0;
            if (t >= 8 && (t - 8) / 24 < nb && (t - 8) % 24 < 16) er = 4'(1 << gseq[(t - 8) / 24]);
            ef = '0;
            u  = t - 9;
            if (u >= 0 && u / 24 < nb && u % 24 < 16) ef = 8'(gseq[u / 24]*32 + u % 24 + 1);
            ev = 1'b0;
            u  = t - 12;
            if (u >= 0 && u / 24 < nb && u % 24 < 16) begin
                ev    = 1'b1;
                exp_d = 8'(gseq[u / 24]*32 + u % 24 + 1 + 64);
                exp_c = 2'(gseq[u / 24]);
            end
            check({tag, "_ready"}, t, ready, er);
            check({tag, "_fir"}, t, fir_out, ef);
            check({tag, "_ovalid"}, t, out_valid, ev);
            check({tag, "_odata"}, t, out_data, exp_d);
            check({tag, "_ochan"}, t, out_chan, exp_c);
            if (out_valid) pulses++;
            @(negedge clk);
        end
        check({tag, "_pulses"}, t_end, pulses, 16*nb);
        check({tag, "_idle"}, t_end, state_dbg, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [3:0] er;
        logic [7:0] ef;
        logic [7:0] exp_d;
        logic [1:0] exp_c;
        logic ev;

        rst   = 1'b1;
        valid = '0;
        data  = '0;

        // Reset values, then ch0 alone with samples 1..16.
        do_reset();
        check("rst_ready", 0, ready, 4'b0);
        check("rst_fir", 0, fir_out, 8'h0);
        check("rst_ovalid", 0, out_valid, 1'b0);
        check("rst_odata", 0, out_data, 8'h0);
        check("rst_ochan", 0, out_chan, 2'd0);
        check("rst_state", 0, state_dbg, 2'd2);
        run_bursts("single", 4'b0001, 1, 40);

        // Long quiet period stays in IDLE.
        for (int t = 0; t < 50; t++) begin
            check("quiet_state", t, state_dbg, 2'd0);
            check("quiet_fir", t, fir_out, 8'h0);
            check("quiet_ready", t, ready, 4'b0);
            check("quiet_ovalid", t, out_valid, 1'b0);
            @(negedge clk);
        end

        // All four channels requesting: grants 0,1,2,3,0.
        do_reset();
        run_bursts("all", 4'b1111, 5, 132);

        // ch2 starves after 5 samples; ch3 is served next.
        do_reset();
        pulses = 0;
        exp_d  = '0;
        exp_c  = '0;
        for (int t = 0; t <= 30; t++) begin
            valid = {(t >= 13 && t < 24), (t < 13), 2'b00};
            set_data(t);
            er = '0;
            if (t >= 8 && t <= 13) er = 4'b0100;
            if (t >= 21 && t <= 24) er = 4'b1000;
            ef = '0;
            if (t >= 9 && t <= 13) ef = 8'(64 + t);
            if (t >= 22 && t <= 24) ef = 8'(96 + t);
            ev = 1'b0;
            if (t >= 12 && t <= 16) begin
                ev = 1'b1; exp_d = 8'(t + 125); exp_c = 2'd2;
            end
            if (t >= 25 && t <= 27) begin
                ev = 1'b1; exp_d = 8'(t + 157); exp_c = 2'd3;
            end
            check("starve_ready", t, ready, er);
            check("starve_fir", t, fir_out, ef);
            check("starve_ovalid", t, out_valid, ev);
            check("starve_odata", t, out_data, exp_d);
            check("starve_ochan", t, out_chan, exp_c);
            if (out_valid && out_chan == 2'd2) pulses++;
            @(negedge clk);
        end
        check("starve_ch2_pulses", 30, pulses, 5);

        // last_grant=1 with ch1 and ch3 both requesting: ch3 first, then ch1.
        do_reset();
        for (int t = 0; t <= 35; t++) begin
            valid = {(t >= 12 && t < 20), 1'b0, (t < 10 || t >= 12), 1'b0};
            set_data(t);
            er = '0;
            if (t >= 8 && t <= 10) er = 4'b0010;
            if (t >= 18 && t <= 20) er = 4'b1000;
            if (t >= 28) er = 4'b0010;
            check("rr_ready", t, ready, er);
            if (t == 12) begin
                check("rr_ovalid_ch1", t, out_valid, 1'b1);
                check("rr_ochan_ch1", t, out_chan, 2'd1);
            end
            if (t == 22) begin
                check("rr_ovalid_ch3", t, out_valid, 1'b1);
                check("rr_ochan_ch3", t, out_chan, 2'd3);
            end
            @(negedge clk);
        end

        // Reset pulse after 7 samples of a ch0 burst; ch0 must be granted again first.
        do_reset();
        for (int t = 0; t <= 30; t++) begin
            valid = 4'b0011;
            set_data(t);
            rst = (t == 15);
            if (t >= 8 && t <= 14) check("mid_rst_ready_pre", t, ready, 4'b0001);
            if (t == 16) begin
                check("mid_rst_fir", t, fir_out, 8'h0);
                check("mid_rst_odata", t, out_data, 8'h0);
                check("mid_rst_ochan", t, out_chan, 2'd0);
                check("mid_rst_state", t, state_dbg, 2'd2);
            end
            if (t >= 16 && t <= 27) check("mid_rst_ovalid", t, out_valid, 1'b0);
            if (t >= 16 && t <= 23) check("mid_rst_ready_flush", t, ready, 4'b0);
            if (t == 24) check("mid_rst_regrant", t, ready, 4'b0001);
            if (t == 28) begin
                check("mid_rst_ovalid_new", t, out_valid, 1'b1);
                check("mid_rst_ochan_new", t, out_chan, 2'd0);
                check("mid_rst_odata_new", t, out_data, 8'd89);
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
